// File: rtl/bullet_hit_scanner_pkg.sv
// Shared definitions for the bullet scanner, the Bullet descriptor source and the renderer.
// Box words pack origin as x/y and extent as w/h, upper byte then lower byte.
package bullet_hit_scanner_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StScan,
    StDrain,
    StDone
  } scan_state_t;

  localparam int unsigned NumBulletsDefault = 16;

  localparam int unsigned XHi = 15;
  localparam int unsigned XLo = 8;
  localparam int unsigned YHi = 7;
  localparam int unsigned YLo = 0;
  localparam int unsigned WHi = 15;
  localparam int unsigned WLo = 8;
  localparam int unsigned HHi = 7;
  localparam int unsigned HLo = 0;

  // Far edge of a box along one axis, widened so 8-bit coordinates never wrap.
  function automatic logic [8:0] end_coord(input logic [7:0] org, input logic [7:0] ext);
    return {1'b0, org} + {1'b0, ext};
  endfunction

endpackage

// File: rtl/bullet_hit_scanner_box_overlap.sv
// Combinational axis-aligned box overlap test; touching edges and empty boxes never overlap.
// Also used by the renderer for point-in-box tests.
module box_overlap
  import bullet_hit_scanner_pkg::*;
(
  input  logic [15:0] a_pos,
  input  logic [15:0] a_size,
  input  logic [15:0] b_pos,
  input  logic [15:0] b_size,
  output logic        overlap
);

  logic [7:0] a_x, a_y, a_w, a_h;
  logic [7:0] b_x, b_y, b_w, b_h;
  logic       non_empty, hit_x, hit_y;

  assign a_x = a_pos[XHi:XLo];
  assign a_y = a_pos[YHi:YLo];
  assign a_w = a_size[WHi:WLo];
  assign a_h = a_size[HHi:HLo];
  assign b_x = b_pos[XHi:XLo];
  assign b_y = b_pos[YHi:YLo];
  assign b_w = b_size[WHi:WLo];
  assign b_h = b_size[HHi:HLo];

  // The strict compares alone would let a zero-extent box hit, so reject it explicitly.
  assign non_empty = (a_w != 8'd0) && (a_h != 8'd0) && (b_w != 8'd0) && (b_h != 8'd0);
  assign hit_x     = ({1'b0, b_x} < end_coord(a_x, a_w)) && ({1'b0, a_x} < end_coord(b_x, b_w));
  assign hit_y     = ({1'b0, b_y} < end_coord(a_y, a_h)) && ({1'b0, a_y} < end_coord(b_y, b_h));
  assign overlap   = non_empty && hit_x && hit_y;

endmodule

// File: rtl/bullet_hit_scanner.sv
// Sweeps every Bullet slot once per start pulse and summarises which rendered bullets
// overlap the player heart box.
module bullet_hit_scanner
  import bullet_hit_scanner_pkg::*;
#(
  parameter int unsigned NUM_BULLETS = NumBulletsDefault,
  parameter int unsigned IDX_W       = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [15:0]      player_pos,
  input  logic [15:0]      player_size,
  output logic [IDX_W-1:0] index,
  input  logic [31:0]      b_state,
  input  logic [15:0]      b_position,
  input  logic [15:0]      b_size,
  input  logic [2:0]       b_color,
  input  logic             b_isRender,
  output logic             busy,
  output logic             done,
  output logic             hit,
  output logic [4:0]       hit_count,
  output logic [IDX_W-1:0] first_hit_index,
  output logic [2:0]       first_hit_color
);

  localparam logic [IDX_W-1:0] LastIdx = IDX_W'(NUM_BULLETS - 1);

  scan_state_t      state_q, state_d;
  logic [IDX_W-1:0] index_q;
  logic [15:0]      ppos_q, psize_q;
  logic             hit_q;
  logic [4:0]       count_q;
  logic [IDX_W-1:0] first_idx_q;
  logic [2:0]       first_color_q;

  logic             accept;
  logic             eval;
  logic [IDX_W-1:0] eval_idx;
  logic             box_hit;
  logic             unused_state;

  assign unused_state = ^b_state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StScan;
      StScan:  if (index_q == LastIdx) state_d = StDrain;
      StDrain: state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    busy = (state_q != StIdle);
    done = (state_q == StDone);
  end

  assign accept = (state_q == StIdle) && start;

  // Read data lags the index by one cycle: in SCAN the sample belongs to index-1,
  // and the DRAIN edge picks up the final slot while index holds.
  assign eval     = ((state_q == StScan) && (index_q != '0)) || (state_q == StDrain);
  assign eval_idx = (state_q == StScan) ? index_q - IDX_W'(1) : index_q;

  box_overlap u_box_overlap (
    .a_pos   (ppos_q),
    .a_size  (psize_q),
    .b_pos   (b_position),
    .b_size  (b_size),
    .overlap (box_hit)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      index_q       <= '0;
      ppos_q        <= '0;
      psize_q       <= '0;
      hit_q         <= 1'b0;
      count_q       <= '0;
      first_idx_q   <= '0;
      first_color_q <= '0;
    end else if (accept) begin
      index_q       <= '0;
      ppos_q        <= player_pos;
      psize_q       <= player_size;
      hit_q         <= 1'b0;
      count_q       <= '0;
      first_idx_q   <= '0;
      first_color_q <= '0;
    end else begin
      if ((state_q == StScan) && (index_q != LastIdx)) index_q <= index_q + IDX_W'(1);
      if (eval && b_isRender && box_hit) begin
        hit_q   <= 1'b1;
        count_q <= count_q + 5'd1;
        if (!hit_q) begin
          first_idx_q   <= eval_idx;
          first_color_q <= b_color;
        end
      end
    end
  end

  assign index           = index_q;
  assign hit             = hit_q;
  assign hit_count       = count_q;
  assign first_hit_index = first_idx_q;
  assign first_hit_color = first_color_q;

endmodule

// File: doc/bullet_hit_scanner.md
Name: bullet_hit_scanner

Overview:
- Consumer and index driver for the Bullet descriptor source.
- Bullet answers per-slot lookups (index in; state/position/size/color/isRender out). This block issues the index sweep and consumes the returned descriptors.
- On a start pulse (one per game tick or frame), it walks every bullet slot and tests each rendered bullet's box against the player heart box.
- Reports hit summary to game logic: hit flag, hit count, first hit slot, first hit colour.

Parameters:
- NUM_BULLETS, 16, number of slots swept (index 0..NUM_BULLETS-1). Must be ≤ 16.
- IDX_W, 4, index width. Matches Bullet index port.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- start  in  1  sweep request; sampled only in IDLE
- player_pos  in  16  player box origin, x=[15:8], y=[7:0]
- player_size  in  16  player box extent, w=[15:8], h=[7:0]
- index  out  4  slot being requested from Bullet
- b_state  in  32  Bullet state word; opaque, ignored here
- b_position  in  16  bullet origin, x=[15:8], y=[7:0]
- b_size  in  16  bullet extent, w=[15:8], h=[7:0]
- b_color  in  3  bullet colour
- b_isRender  in  1  slot active
- busy  out  1  sweep in progress
- done  out  1  one-cycle pulse, results valid
- hit  out  1  ≥1 overlapping bullet
- hit_count  out  5  number of overlapping bullets (0..16)
- first_hit_index  out  4  lowest overlapping slot
- first_hit_color  out  3  colour of that slot

Behaviour:
- Reset (asynchronous, active-high; immediate on assertion, including mid-sweep):
  - State goes to IDLE; sweep aborted, partial results discarded.
  - index=0, busy=0, done=0, hit=0, hit_count=0, first_hit_index=0, first_hit_color=0.
- Bullet read latency is fixed at 1 cycle: fields returned for the index driven in cycle c are sampled at the end of cycle c+1.
- FSM states: IDLE, SCAN, DRAIN, DONE.
  - IDLE: start=1 at edge E0 → SCAN. At E0:
    - index←0, busy←1.
    - Latch player_pos and player_size; later changes during the sweep are ignored.
    - Clear accumulators (hit, hit_count, first_hit_index, first_hit_color).
  - SCAN: index increments each edge. At index=NUM_BULLETS-1 → DRAIN; index holds its value.
    - From E2 onward, each edge evaluates the sample belonging to index k, where k = edge number − 2.
  - DRAIN: one edge. Evaluates the last slot (NUM_BULLETS-1) at E(NUM_BULLETS+1), then → DONE.
  - DONE: done=1 for exactly one cycle. Then → IDLE; busy←0 on the edge leaving DONE.
- Timing with default N=16:
  - busy high from E0 through E18.
  - done high in the cycle after E17, i.e. N+2 edges from the start edge.
- start is ignored while busy (no queueing). start held high re-triggers on the first IDLE edge after DONE.
- Result outputs hold their values until the next accepted start, then clear.
- Overlap test, evaluated only when b_isRender=1; unrendered slots never hit:
  - hit_x = bx < px+pw and px < bx+bw
  - hit_y = by < py+ph and py < by+bh
  - All sums computed at 9 bits, so no 8-bit wrap-around.
  - Boxes touching at an edge do not overlap.
  - w=0 or h=0 on either box → no hit.
- Accumulation on each hit:
  - hit_count += 1; saturation is not needed, max 16 fits in 5 bits.
  - first_hit_index and first_hit_color are written only on the first hit of the sweep (lowest slot wins).
- b_state is not interpreted.

Decomposition:
- Shared package:
  - FSM state encoding.
  - Field slice constants: X=[15:8], Y=[7:0], W=[15:8], H=[7:0].
  - Default NUM_BULLETS.
  - The same constants are reused by Bullet and the renderer.
- One sub-module: box_overlap. Purely combinational: two (pos,size) pairs in, 1-bit overlap out. It is reused by the pixel renderer for point-in-box tests.

Test Plan:
- Reset mid-sweep: start, assert reset at E5 → all outputs 0 immediately, index=0. Release, start → full sweep completes normally.
- No rendered bullets: all b_isRender=0, start → done after 18 edges, hit=0, hit_count=0, index sequence observed 0..15.
- Single hit: player at (100,100) size (16,16); slot 5 at (110,105) size (4,4), colour 3 → hit=1, hit_count=1, first_hit_index=5, first_hit_color=3.
- Edge/boundary cases, all → hit=0:
  - slot 2 at (116,100) size (4,4), touching the right edge.
  - slot 3 at (104,104) size (0,8), zero width.
  - slot 4 at (250,250) size (10,10), no 8-bit wrap false-hit with player at (0,0) size (8,8).
- Multiple hits: slots 1, 7, 15 overlap, colours 6/2/1 → hit_count=3, first_hit_index=1, first_hit_color=6. Player moved mid-sweep → result unchanged (values latched at E0).
- Start while busy: pulse start at E4 and E10 → ignored, single done. Start held high continuously → back-to-back sweeps, done every 19 cycles (18 edges of sweep + 1 IDLE edge).
